// File: rtl/nor_bank_pkg.sv
// Shared bounds and counter sizing helper for the nor_bank gate array.
package nor_bank_pkg;

    localparam int MAX_CHANNELS = 64;
    localparam int MAX_FAN_IN   = 8;
    localparam int MAX_STAGES   = 8;

    // Bits needed for a counter that must hold the value `limit`.
    function automatic int cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/nor_bank_osc_mon.sv
// Per-channel toggle counter and sticky oscillation flag, closed by a shared window-wrap strobe.
module nor_bank_osc_mon
    import nor_bank_pkg::*;
#(
    parameter int OSC_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic toggle,
    input  logic wrap,
    input  logic osc_clr,
    output logic osc
);

    localparam int CW = cnt_w(OSC_LIMIT + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_eff;
    logic          det;

    // A toggle landing on the wrap cycle belongs to the window being closed.
    always_comb begin
        cnt_eff = cnt;
        if (toggle && cnt != CW'(OSC_LIMIT + 1))
            cnt_eff = cnt + 1'b1;
        det = wrap && (cnt_eff > CW'(OSC_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            osc <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt_eff;
            osc <= det | (osc & ~osc_clr);
        end
    end

endmodule

// File: rtl/nor_bank.sv
// Bank of FAN_IN-input NOR gates: negedge sample, STAGES posedge delay, settle monitor.
// Oscillation detector built only when NOR_BANK_OSC_DETECT_EN is defined.
module nor_bank
    import nor_bank_pkg::*;
#(
    parameter int                  CHANNELS      = 8,
    parameter int                  FAN_IN        = 3,
    parameter int                  STAGES        = 1,
    parameter logic [CHANNELS-1:0] IV            = '0,
    parameter int                  SETTLE_CYCLES = 4,
    parameter int                  OSC_WINDOW    = 64,
    parameter int                  OSC_LIMIT     = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS*FAN_IN-1:0] a,
    input  logic                       osc_clr,
    output logic [CHANNELS-1:0]        y,
    output logic                       settled,
    output logic [CHANNELS-1:0]        osc
);

    localparam int SW = cnt_w(SETTLE_CYCLES);

    logic [CHANNELS-1:0]             nor_v;
    logic [CHANNELS-1:0]             s;
    logic [STAGES-1:0][CHANNELS-1:0] pipe;
    logic [STAGES-1:0][CHANNELS-1:0] pipe_next;
    logic [CHANNELS-1:0]             y_next;
    logic [SW-1:0]                   set_cnt;
    logic [SW-1:0]                   set_cnt_n;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_nor
        assign nor_v[g] = ~|a[g*FAN_IN +: FAN_IN];
    end

    always_ff @(negedge clk) begin
        if (rst) s <= IV;
        else     s <= nor_v;
    end

    always_comb begin
        pipe_next[0] = s;
        for (int j = 1; j < STAGES; j++)
            pipe_next[j] = pipe[j-1];
        if (rst)
            pipe_next = {STAGES{IV}};
    end

    always_ff @(posedge clk) begin
        pipe <= pipe_next;
    end

    assign y      = pipe[STAGES-1];
    assign y_next = pipe_next[STAGES-1];

    always_comb begin
        set_cnt_n = set_cnt;
        if (y_next != y)
            set_cnt_n = '0;
        else if (set_cnt != SW'(SETTLE_CYCLES))
            set_cnt_n = set_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            set_cnt <= '0;
            settled <= 1'b0;
        end else begin
            set_cnt <= set_cnt_n;
            settled <= (set_cnt_n == SW'(SETTLE_CYCLES));
        end
    end

`ifdef NOR_BANK_OSC_DETECT_EN
    localparam int WW = cnt_w(OSC_WINDOW - 1);

    logic [WW-1:0]       win;
    logic                wrap;
    logic [CHANNELS-1:0] tgl;

    assign wrap = (win == WW'(OSC_WINDOW - 1));
    assign tgl  = y_next ^ y;

    always_ff @(posedge clk) begin
        if (rst)       win <= '0;
        else if (wrap) win <= '0;
        else           win <= win + 1'b1;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_mon
        nor_bank_osc_mon #(
            .OSC_LIMIT (OSC_LIMIT)
        ) u_mon (
            .clk     (clk),
            .rst     (rst),
            .toggle  (tgl[g]),
            .wrap    (wrap),
            .osc_clr (osc_clr),
            .osc     (osc[g])
        );
    end
`else
    logic unused_osc_clr;
    assign unused_osc_clr = osc_clr;
    assign osc            = '0;
`endif

endmodule

// File: tb/tb_nor_bank.sv
// Bench for nor_bank: two instances (STAGES=1 and STAGES=3) against a step-indexed reference model.
module tb_nor_bank;

    localparam int C  = 4;
    localparam int F  = 3;
    localparam int SET = 4;
    localparam int W  = 16;
    localparam int L  = 3;
    localparam int NS = 1024;
    localparam logic [C-1:0] IV1 = 4'b1010;
    localparam logic [C-1:0] IV3 = 4'b0110;
`ifdef NOR_BANK_OSC_DETECT_EN
    localparam bit OSC_ON = 1'b1;
`else
    localparam bit OSC_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         osc_clr;
    logic [C*F-1:0] a;
    logic [C-1:0] y1, y3, osc1, osc3;
    logic         settled1, settled3;

    always #5 clk = ~clk;

    nor_bank #(.CHANNELS(C), .FAN_IN(F), .STAGES(1), .IV(IV1), .SETTLE_CYCLES(SET),
               .OSC_WINDOW(W), .OSC_LIMIT(L)) dut1 (
        .clk(clk), .rst(rst), .a(a), .osc_clr(osc_clr),
        .y(y1), .settled(settled1), .osc(osc1));

    nor_bank #(.CHANNELS(C), .FAN_IN(F), .STAGES(3), .IV(IV3), .SETTLE_CYCLES(SET),
               .OSC_WINDOW(W), .OSC_LIMIT(L)) dut3 (
        .clk(clk), .rst(rst), .a(a), .osc_clr(osc_clr),
        .y(y3), .settled(settled3), .osc(osc3));

    // Reference model state, indexed by step (one negedge followed by one posedge).
    logic [C*F-1:0] a_hist [NS];
    bit             rst_hist [NS];
    int             k = 0;
    logic [C-1:0]   ye [2];
    logic [C-1:0]   oe [2];
    bit             se [2];
    int             last_ev [2];
    int             since [2];
    int             tog [2][C];
    int             n_pass = 0, n_chk = 0, n_fail = 0;

    function automatic logic [C-1:0] nor_of(input logic [C*F-1:0] v);
        logic [C-1:0] r;
        for (int i = 0; i < C; i++) r[i] = (v[i*F +: F] == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s step %0d: got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // y at step k is the NOR of inputs from step k-S+1, or IV if any reset fell in that span.
    task automatic model_step();
        int           S;
        bit           rin;
        logic [C-1:0] ynew;
        logic [C-1:0] ivd;
        for (int d = 0; d < 2; d++) begin
            S   = (d == 0) ? 1 : 3;
            ivd = (d == 0) ? IV1 : IV3;
            rin = 1'b0;
            for (int j = k - S + 1; j <= k; j++)
                if (j < 0 || rst_hist[j]) rin = 1'b1;
            ynew = rin ? ivd : nor_of(a_hist[k - S + 1]);
            if (rst_hist[k]) begin
                last_ev[d] = k;
                since[d]   = 0;
                oe[d]      = '0;
                for (int i = 0; i < C; i++) tog[d][i] = 0;
            end else begin
                if (ynew != ye[d]) last_ev[d] = k;
                since[d]++;
                for (int i = 0; i < C; i++) tog[d][i] += (ynew[i] != ye[d][i]) ? 1 : 0;
                for (int i = 0; i < C; i++) begin
                    if (since[d] % W == 0) begin
                        oe[d][i]  = (tog[d][i] > L) | (oe[d][i] & ~osc_clr);
                        tog[d][i] = 0;
                    end else begin
                        oe[d][i] = oe[d][i] & ~osc_clr;
                    end
                end
            end
            se[d] = !rst_hist[k] && (k - last_ev[d] >= SET);
            ye[d] = ynew;
        end
    endtask

    task automatic step();
        a_hist[k]   = a;
        rst_hist[k] = rst;
        @(negedge clk);
        @(posedge clk);
        model_step();
        #1;
        chk("y1", 8'(y1), 8'(ye[0]));
        chk("y3", 8'(y3), 8'(ye[1]));
        chk("settled1", 8'(settled1), 8'(se[0]));
        chk("settled3", 8'(settled3), 8'(se[1]));
        chk("osc1", 8'(osc1), OSC_ON ? 8'(oe[0]) : 8'h00);
        chk("osc3", 8'(osc3), OSC_ON ? 8'(oe[1]) : 8'h00);
        k++;
    endtask

    initial begin
        rst = 1'b1; a = '0; osc_clr = 1'b0;
        step();                                   // reset posedge
        chk("rst_y1", 8'(y1), 8'h0A);
        chk("rst_y3", 8'(y3), 8'h06);
        chk("rst_settled", 8'(settled1), 8'h00);
        chk("rst_osc", 8'(osc1), 8'h00);
        rst = 1'b0;
        step();                                   // first sampled negedge with a=0
        chk("rel_y1", 8'(y1), 8'h0F);
        chk("rel_y3_iv", 8'(y3), 8'h06);
        repeat (5) step();
        chk("settle_rise", 8'(settled1), 8'h01);
        a[0] = 1'b1;
        step();
        chk("lat_n1", 8'(y3[0]), 8'h01);
        chk("settle_drop", 8'(settled1), 8'h00);
        step();
        chk("lat_n2", 8'(y3[0]), 8'h01);
        step();
        chk("lat_n3", 8'(y3[0]), 8'h00);
        step();
        chk("settle_wait", 8'(settled1), 8'h00);
        step();
        chk("settle_back", 8'(settled1), 8'h01);

        // Oscillation on channel 2, window aligned to a fresh reset.
        rst = 1'b1; a = '0;
        step();
        rst = 1'b0;
        repeat (15) begin a[6] = ~a[6]; step(); end
        chk("osc_pre_wrap", 8'(osc1), 8'h00);
        a[6] = ~a[6];
        step();
        chk("osc_wrap", 8'(osc1), OSC_ON ? 8'h04 : 8'h00);
        osc_clr = 1'b1;
        step();
        chk("osc_clr", 8'(osc1), 8'h00);
        osc_clr = 1'b0;

        // Exactly L toggles, the last on the wrap cycle.
        repeat (12) step();
        repeat (3) begin a[3] = ~a[3]; step(); end
        chk("osc_limit_ok", 8'(osc1), 8'h00);

        // L+1 toggles, the last on the wrap cycle, with osc_clr coincident.
        repeat (12) step();
        repeat (3) begin a[3] = ~a[3]; step(); end
        a[3] = ~a[3]; osc_clr = 1'b1;
        step();
        chk("osc_set_wins", 8'(osc1), OSC_ON ? 8'h02 : 8'h00);
        osc_clr = 1'b0;

        repeat (300) begin
            if ($urandom_range(0, 2) == 0)
                for (int i = 0; i < C; i++)
                    a[i*F +: F] = ($urandom_range(0, 1) == 0) ? '0 : F'($urandom_range(1, 7));
            osc_clr = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
